instr_fetch: RTL and testbench

Instruction-fetch stage of the MIPS pipeline. Reads the current PC from the PC register, computes the next PC (PC+4, branch target or jump target), and drives the PC register's input and enable. Holds the program memory and the IF/ID pipeline register. A small control FSM sequences program load, run and halt.

---
 rtl/instr_fetch.sv | 68 ++++++
 tb/tb_instr_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch stage with program memory, next-PC select, IF/ID register and load/run/halt FSM.
module instr_fetch #(
  parameter int len = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [len-1:0]    pc_in,
  output logic [len-1:0]    pc_next,
  output logic              pc_enable,
  input  logic              start,
  input  logic              stall,
  input  logic              jump,
  input  logic [len-1:0]    jump_target,
  input  logic              branch_taken,
  input  logic [len-1:0]    branch_target,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       if_id_instr,
  output logic [len-1:0]    if_id_pc_plus4,
  output logic              if_id_valid,
  output logic              halted
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state_q, state_d;
  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] fetched, if_id_instr_q, if_id_instr_d;
  logic [len-1:0] pc_plus4, if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic if_id_valid_q, if_id_valid_d, run, load, flush;
  assign run = state_q == RUN;
  assign pc_plus4 = pc_in + len'(4);
  // Addresses past the end of memory read as the halt word so runaway fetch stops.
  assign fetched = (pc_in[len-1:ADDR_W+2] != '0) ? HALT_WORD : mem[pc_in[ADDR_W+1:2]];
  assign flush = !run || branch_taken || (!stall && jump);
  assign load = run && !branch_taken && !stall && !jump;
  assign pc_next = branch_taken ? branch_target : (jump && !stall) ? jump_target : pc_plus4;
  assign pc_enable = run && (branch_taken || !stall);
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_valid = if_id_valid_q;
  assign halted = state_q == HALTED;
  always_comb begin
    if_id_instr_d = flush ? '0 : load ? fetched : if_id_instr_q;
    if_id_pc_plus4_d = flush ? '0 : load ? pc_plus4 : if_id_pc_plus4_q;
    if_id_valid_d = flush ? 1'b0 : load ? 1'b1 : if_id_valid_q;
    state_d = (state_q == IDLE && start) ? RUN : (load && fetched == HALT_WORD) ? HALTED : state_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      if_id_instr_q <= '0;
      if_id_pc_plus4_q <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end
  // Program memory survives reset; it is loadable only while idle.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && prog_we) mem[prog_addr] <= prog_data;
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a behavioural model.
module tb_instr_fetch;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  logic clk = 0, reset = 0;
  logic [31:0] pc_in = 0, pc_next, jump_target = 0, branch_target = 0, prog_data = 0;
  logic [31:0] if_id_instr, if_id_pc_plus4;
  logic pc_enable, start = 0, stall = 0, jump = 0, branch_taken = 0, prog_we = 0;
  logic if_id_valid, halted;
  logic [7:0] prog_addr = 0;
  int total = 0, bad = 0;
  bit pc_follow = 0;
  logic [31:0] mem_m [256];
  bit m_run = 0, m_halt = 0, id_v = 0;
  logic [31:0] id_instr = 0, id_pc4 = 0;

  instr_fetch dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_next(pc_next), .pc_enable(pc_enable),
    .start(start), .stall(stall), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] fetch(input logic [31:0] p);
    logic [31:0] q;
    q = p;
    return (q >= 32'd1024) ? HALT : mem_m[q[9:2]];
  endfunction
  function automatic logic [31:0] exp_next();
    return branch_taken ? branch_target : (jump && !stall) ? jump_target : pc_in + 32'd4;
  endfunction
  function automatic bit exp_en();
    return m_run && (branch_taken || !stall);
  endfunction

  task automatic model_clear();
    m_run = 0; m_halt = 0; id_v = 0; id_instr = 0; id_pc4 = 0;
  endtask

  task automatic model_update();
    logic [31:0] f;
    f = fetch(pc_in);
    if (m_run) begin
      if (branch_taken || (!stall && jump)) begin
        id_v = 0; id_instr = 0; id_pc4 = 0;
      end else if (!stall) begin
        id_v = 1; id_instr = f; id_pc4 = pc_in + 32'd4;
        if (f == HALT) begin m_run = 0; m_halt = 1; end
      end
    end else begin
      id_v = 0; id_instr = 0; id_pc4 = 0;
      if (!m_halt && prog_we) mem_m[prog_addr] = prog_data;
      if (!m_halt && start) m_run = 1;
    end
  endtask

  task automatic step();
    bit en;
    logic [31:0] nx;
    @(posedge clk);
    en = exp_en();
    nx = exp_next();
    if (reset) model_update();
    #1;
    if (pc_follow && en) pc_in = nx;
  endtask

  task automatic restart();
    reset = 0;
    model_clear();
    #3;
    reset = 1;
    start = 1;
    step();
    start = 0;
  endtask

  task automatic chk_ifid(input string n, input logic [31:0] i, input logic [31:0] p, input logic v);
    chk({n, "_instr"}, if_id_instr, i);
    chk({n, "_pc4"}, if_id_pc_plus4, p);
    chk({n, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
  endtask

  always @(negedge clk) begin
    chk("cmp_pc_next", pc_next, exp_next());
    chk("cmp_pc_enable", {31'b0, pc_enable}, {31'b0, exp_en()});
    chk("cmp_instr", if_id_instr, id_instr);
    chk("cmp_pc4", if_id_pc_plus4, id_pc4);
    chk("cmp_valid", {31'b0, if_id_valid}, {31'b0, id_v});
    chk("cmp_halted", {31'b0, halted}, {31'b0, m_halt});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    #12;
    chk_ifid("reset", 0, 0, 0);
    chk("reset_halted", {31'b0, halted}, 0);
    chk("reset_pc_enable", {31'b0, pc_enable}, 0);
    reset = 1;
    for (int a = 0; a < 256; a++) begin
      case (a)
        0: w = 32'h20010005;
        1: w = 32'h20020003;
        2: w = HALT;
        3: w = 32'h8C030000;
        4: w = 32'h00221820;
        5: w = 32'h00A51020;
        8: w = 32'h01234567;
        16: w = 32'hAC040010;
        default: w = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
      endcase
      prog_we = 1; prog_addr = 8'(a); prog_data = w;
      step();
    end
    prog_we = 0;
    // program run to the halt word
    start = 1; step(); start = 0;
    pc_follow = 1; pc_in = 0;
    step(); chk_ifid("seq0", 32'h20010005, 4, 1);
    step(); chk_ifid("seq1", 32'h20020003, 8, 1);
    step(); chk_ifid("seq2", HALT, 12, 1);
    chk("seq_halted", {31'b0, halted}, 1);
    chk("seq_pc_enable", {31'b0, pc_enable}, 0);
    step(); chk_ifid("seq_after", 0, 0, 0);
    // stall holds IF/ID and the PC
    pc_follow = 0;
    restart();
    pc_in = 32'h0C; step(); chk_ifid("pre_stall", 32'h8C030000, 32'h10, 1);
    pc_in = 32'h10; stall = 1; #1;
    chk("stall_pc_enable", {31'b0, pc_enable}, 0);
    step(); chk_ifid("stall1", 32'h8C030000, 32'h10, 1);
    step(); chk_ifid("stall2", 32'h8C030000, 32'h10, 1);
    stall = 0; #1;
    chk("resume_pc_next", pc_next, 32'h14);
    step(); chk_ifid("resume", 32'h00221820, 32'h14, 1);
    // branch beats stall and jump
    branch_taken = 1; branch_target = 32'h40; stall = 1; jump = 1; jump_target = 32'h80; #1;
    chk("br_pc_next", pc_next, 32'h40);
    chk("br_pc_enable", {31'b0, pc_enable}, 1);
    step(); chk_ifid("br_flush", 0, 0, 0);
    branch_taken = 0; stall = 0;
    // halt word under jump is flushed, not halting
    pc_in = 32'h8; jump_target = 32'h20; #1;
    chk("jh_pc_next", pc_next, 32'h20);
    step(); chk_ifid("jh_flush", 0, 0, 0);
    chk("jh_halted", {31'b0, halted}, 0);
    jump = 0; pc_in = 32'h20;
    step(); chk_ifid("jh_cont", 32'h01234567, 32'h24, 1);
    // out-of-range fetch halts; a RUN-time write is ignored
    prog_we = 1; prog_addr = 5; prog_data = 32'hDEADBEEF; pc_in = 32'h400;
    step(); chk_ifid("oor", HALT, 32'h404, 1);
    chk("oor_halted", {31'b0, halted}, 1);
    prog_we = 0;
    restart();
    pc_in = 32'h14; step(); chk_ifid("readback", 32'h00A51020, 32'h18, 1);
    // asynchronous reset mid-run
    #2; reset = 0; model_clear(); #1;
    chk_ifid("async", 0, 0, 0);
    chk("async_halted", {31'b0, halted}, 0);
    chk("async_pc_enable", {31'b0, pc_enable}, 0);
    #2; reset = 1;
    start = 1; step(); start = 0;
    pc_in = 0; step(); chk_ifid("rerun", 32'h20010005, 4, 1);
    // randomized traffic
    pc_follow = 1;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 9) == 0);
      prog_we = ($urandom_range(0, 1) == 0);
      prog_addr = 8'($urandom);
      prog_data = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      stall = ($urandom_range(0, 4) == 0);
      jump = ($urandom_range(0, 9) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      jump_target = $urandom_range(0, 270) * 4;
      branch_target = $urandom_range(0, 270) * 4;
      if ($urandom_range(0, 19) == 0) pc_in = $urandom_range(0, 270) * 4 + $urandom_range(0, 3);
      if (m_halt && $urandom_range(0, 3) == 0) begin
        reset = 0; model_clear(); #2; reset = 1;
        pc_in = 0;
      end
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
